// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
//
// Packet transmitter that feeds the router's input port. The host streams
// payload bytes into an internal FIFO; on a send request the transmitter
// serialises one packet onto din/pkt_valid:
//
//   header {len[5:0], addr[1:0]}  (pkt_valid = 1)
//   len payload bytes             (pkt_valid = 1)
//   parity byte                   (pkt_valid = 0)
//   one idle gap cycle
//
// Parity is the 8-bit XOR of the header and every payload byte. A byte on
// din is consumed only at a clock edge where busy is low; while busy is high
// din/pkt_valid hold, the buffer is not popped and parity is not updated.
//
// Handshake semantics:
//   - payload write side: a byte is written at an edge where
//     pl_valid && pl_ready; pl_ready is low only when the buffer is full.
//   - router side: the byte on din is taken at an edge where busy == 0.
//   - send is sampled only in IDLE; elsewhere it is ignored.
//
// Parameters:
//   PL_DEPTH        payload buffer depth in bytes (power of two, >= 63)
//
// Ports:
//   clk             sole clock, rising edge
//   reset           synchronous, active-high; clears all state
//   send            request to transmit one packet (IDLE only)
//   tx_addr[1:0]    destination port 0..2 (3 is illegal)
//   tx_len[5:0]     payload length 1..63 (0 is illegal)
//   pl_data[7:0]    payload byte from host
//   pl_valid        pl_data valid
//   pl_ready        buffer not full
//   busy            router back-pressure
//   inj_parity_err  (ROUTER_TX_PARITY_INJ_EN only) invert this packet's parity
//   din[7:0]        byte to router
//   pkt_valid       high on header and payload bytes
//   tx_active       high from send acceptance until return to IDLE
//   tx_done         one-cycle pulse on entering IDLE after a packet
//   req_err         one-cycle pulse when a send request is rejected
//   pl_count        bytes currently buffered (0..PL_DEPTH)
//   dbg_state[2:0]  current FSM state encoding, for observation
//
// Build option:
//   ROUTER_TX_PARITY_INJ_EN  adds the inj_parity_err input; when it is set at
//   send acceptance the parity byte of that packet is bitwise inverted.
// ---------------------------------------------------------------------------
module router_pkt_tx #(
    parameter int PL_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      send,
    input  logic [1:0]                tx_addr,
    input  logic [5:0]                tx_len,
    input  logic [7:0]                pl_data,
    input  logic                      pl_valid,
    output logic                      pl_ready,
    input  logic                      busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic                      inj_parity_err,
`endif
    output logic [7:0]                din,
    output logic                      pkt_valid,
    output logic                      tx_active,
    output logic                      tx_done,
    output logic                      req_err,
    output logic [$clog2(PL_DEPTH):0] pl_count,
    output logic [2:0]                dbg_state
);

    localparam int PW = $clog2(PL_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_HEADER    = 3'd2,
        S_PAYLOAD   = 3'd3,
        S_PARITY    = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Payload FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [PL_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_n;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    head;
    logic [7:0]    next_head;

    assign wr_en     = pl_valid && pl_ready;
    assign head      = mem[rd_ptr];
    // The byte after the head is already stored whenever a packet is in
    // PAYLOAD, because the header is only launched once len bytes are present.
    assign next_head = mem[rd_ptr + PW'(1)];
    assign pl_count  = count_q;

    always_comb begin
        count_n = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            pl_ready <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            count_q  <= count_n;
            // Registered full flag, computed from the next count so it is
            // exact in the cycle the buffer fills or drains.
            pl_ready <= (count_n != CW'(PL_DEPTH));
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pl_data;
    end

    // -----------------------------------------------------------------------
    // Request qualification
    // -----------------------------------------------------------------------
    state_t state_q;
    state_t state_n;
    logic   req_legal;
    logic   accept;

    assign req_legal = (tx_addr != 2'd3) && (tx_len != 6'd0);
    assign accept    = (state_q == S_IDLE) && send && req_legal;
    assign dbg_state = state_q;

    // -----------------------------------------------------------------------
    // Optional parity corruption
    // -----------------------------------------------------------------------
    logic [7:0] parity_mask;

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic inj_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= inj_parity_err;
        end
    end

    assign parity_mask = {8{inj_q}};
`else
    assign parity_mask = 8'h00;
`endif

    // -----------------------------------------------------------------------
    // Transmit FSM
    // -----------------------------------------------------------------------
    logic [5:0] len_q;
    logic [5:0] len_n;
    logic [1:0] addr_q;
    logic [1:0] addr_n;
    logic [5:0] remaining_q;
    logic [5:0] remaining_n;
    logic [7:0] parity_q;
    logic [7:0] parity_n;
    logic [7:0] din_n;
    logic       pkt_valid_n;
    logic       tx_active_n;
    logic       tx_done_n;
    logic       req_err_n;
    logic [7:0] hdr_req;
    logic [7:0] hdr_lat;
    logic [7:0] parity_final;

    assign hdr_req      = {tx_len, tx_addr};
    assign hdr_lat      = {len_q, addr_q};
    // Parity including the payload byte being consumed this edge.
    assign parity_final = (parity_q ^ din) ^ parity_mask;

    always_comb begin
        state_n     = state_q;
        len_n       = len_q;
        addr_n      = addr_q;
        remaining_n = remaining_q;
        parity_n    = parity_q;
        din_n       = din;
        pkt_valid_n = pkt_valid;
        tx_done_n   = 1'b0;
        req_err_n   = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                din_n       = 8'h00;
                pkt_valid_n = 1'b0;
                if (send) begin
                    if (req_legal) begin
                        len_n       = tx_len;
                        addr_n      = tx_addr;
                        remaining_n = tx_len;
                        if (count_q >= CW'(tx_len)) begin
                            state_n     = S_HEADER;
                            din_n       = hdr_req;
                            pkt_valid_n = 1'b1;
                            parity_n    = hdr_req;
                        end else begin
                            state_n = S_WAIT_DATA;
                        end
                    end else begin
                        req_err_n = 1'b1;
                    end
                end
            end

            S_WAIT_DATA: begin
                din_n       = 8'h00;
                pkt_valid_n = 1'b0;
                if (count_q >= CW'(len_q)) begin
                    state_n     = S_HEADER;
                    din_n       = hdr_lat;
                    pkt_valid_n = 1'b1;
                    parity_n    = hdr_lat;
                end
            end

            S_HEADER: begin
                if (!busy) begin
                    state_n     = S_PAYLOAD;
                    din_n       = head;
                    pkt_valid_n = 1'b1;
                end
            end

            S_PAYLOAD: begin
                if (!busy) begin
                    // din currently shows the FIFO head; consuming it pops.
                    rd_en       = 1'b1;
                    parity_n    = parity_q ^ din;
                    remaining_n = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        state_n     = S_PARITY;
                        din_n       = parity_final;
                        pkt_valid_n = 1'b0;
                    end else begin
                        din_n       = next_head;
                        pkt_valid_n = 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (!busy) begin
                    state_n     = S_GAP;
                    din_n       = 8'h00;
                    pkt_valid_n = 1'b0;
                end
            end

            S_GAP: begin
                state_n     = S_IDLE;
                din_n       = 8'h00;
                pkt_valid_n = 1'b0;
                tx_done_n   = 1'b1;
            end

            default: begin
                state_n     = S_IDLE;
                din_n       = 8'h00;
                pkt_valid_n = 1'b0;
            end
        endcase

        tx_active_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            parity_q    <= '0;
            din         <= '0;
            pkt_valid   <= 1'b0;
            tx_active   <= 1'b0;
            tx_done     <= 1'b0;
            req_err     <= 1'b0;
        end else begin
            state_q     <= state_n;
            len_q       <= len_n;
            addr_q      <= addr_n;
            remaining_q <= remaining_n;
            parity_q    <= parity_n;
            din         <= din_n;
            pkt_valid   <= pkt_valid_n;
            tx_active   <= tx_active_n;
            tx_done     <= tx_done_n;
            req_err     <= req_err_n;
        end
    end

endmodule
